// File: rtl/cpu_ctrl.sv
// Instruction-sequencing controller for the 5-bit-address CISC core: fetch, decode and
// operand access with a ready handshake and a per-access timeout watchdog.
module cpu_ctrl #(
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 8,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    input  logic          zero,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          addr_sel,
    output logic          ld_pc,
    output logic          inc_pc,
    output logic [AW-1:0] pc_in,
    output logic          ld_acc,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] ir_out,
    output logic          halted,
    output logic          mem_err
);

    localparam int unsigned WW = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_RDOP   = 3'd2;
    localparam logic [2:0] S_WROP   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [DW-1:0] r_ir;
    logic          w_ld_ir;
    logic [WW-1:0] r_wait;
    logic [WW-1:0] w_wait_nxt;
    logic [2:0]    w_opcode;
    logic          w_timeout;
    logic          w_run;

    assign w_opcode = r_ir[DW-1:DW-3];
    // This wait cycle would be the WAIT_MAX-th one with no ready: give up.
    assign w_timeout = !mem_ready && (r_wait == WW'(WAIT_MAX - 1));
    assign w_run     = !reset;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = '0;
        w_ld_ir     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_ld_ir     = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            S_DECODE: begin
                unique case (w_opcode)
                    OP_HLT: w_state_nxt = S_HALT;
                    OP_SKZ: w_state_nxt = S_FETCH;
                    OP_JMP: w_state_nxt = S_FETCH;
                    OP_ADD: w_state_nxt = S_RDOP;
                    OP_AND: w_state_nxt = S_RDOP;
                    OP_XOR: w_state_nxt = S_RDOP;
                    OP_LDA: w_state_nxt = S_RDOP;
                    OP_STO: w_state_nxt = S_WROP;
                endcase
            end
            S_RDOP, S_WROP: begin
                if (mem_ready) begin
                    w_state_nxt = S_FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            if (w_ld_ir) begin
                r_ir <= mem_rdata;
            end
        end
    end

    // Reset gates the commands directly so strobes drop without waiting for a clock edge.
    always_comb begin
        mem_rd   = w_run && ((r_state == S_FETCH) || (r_state == S_RDOP));
        mem_wr   = w_run && (r_state == S_WROP);
        addr_sel = w_run && ((r_state == S_RDOP) || (r_state == S_WROP));
        inc_pc   = w_run && (((r_state == S_FETCH) && mem_ready) ||
                             ((r_state == S_DECODE) && (w_opcode == OP_SKZ) && zero));
        ld_pc    = w_run && (r_state == S_DECODE) && (w_opcode == OP_JMP);
        ld_acc   = w_run && (r_state == S_RDOP) && mem_ready;
        halted   = w_run && ((r_state == S_HALT) || (r_state == S_ERR));
        mem_err  = w_run && (r_state == S_ERR);
        pc_in    = r_ir[AW-1:0];
        alu_op   = w_opcode;
        ir_out   = r_ir;
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: directed per-cycle vectors push expected outputs,
// a monitor on the falling edge pops and compares.
module tb_cpu_ctrl;

    localparam logic [7:0] RD = 8'h80;
    localparam logic [7:0] WR = 8'h40;
    localparam logic [7:0] AS = 8'h20;
    localparam logic [7:0] LP = 8'h10;
    localparam logic [7:0] IP = 8'h08;
    localparam logic [7:0] LA = 8'h04;
    localparam logic [7:0] HT = 8'h02;
    localparam logic [7:0] ER = 8'h01;

    typedef struct {
        string       name;
        logic [23:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       mem_rd, mem_wr, addr_sel, ld_pc, inc_pc, ld_acc, halted, mem_err;
    logic [4:0] pc_in;
    logic [2:0] alu_op;
    logic [7:0] ir_out;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    cpu_ctrl #(.AW(5), .DW(8), .WAIT_MAX(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .zero      (zero),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .addr_sel  (addr_sel),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .pc_in     (pc_in),
        .ld_acc    (ld_acc),
        .alu_op    (alu_op),
        .ir_out    (ir_out),
        .halted    (halted),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs shortly after the rising edge and record the expected outputs.
    task automatic step(input string name, input logic rst, input logic [7:0] rdata,
                        input logic rdy, input logic z, input logic [7:0] flags,
                        input logic [7:0] ir);
        exp_t e;
        @(posedge clk);
        #2;
        reset     = rst;
        mem_rdata = rdata;
        mem_ready = rdy;
        zero      = z;
        e.name = name;
        e.v    = {flags, ir[4:0], ir[7:5], ir};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [23:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {mem_rd, mem_wr, addr_sel, ld_pc, inc_pc, ld_acc, halted, mem_err,
                       pc_in, alu_op, ir_out};
                n_checks++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %06h expected %06h", e.name, act, e.v);
                end
            end
        end
    end

    initial begin : stim
        step("reset_hold", 1, 8'h00, 1, 0, 8'h00, 8'h00);
        // JMP 10
        step("jmp_fetch", 0, 8'hEA, 1, 0, RD | IP, 8'h00);
        step("jmp_decode", 0, 8'h00, 1, 0, LP, 8'hEA);
        // ADD 7 with operand delayed 3 cycles
        step("add_fetch", 0, 8'h47, 1, 0, RD | IP, 8'hEA);
        step("add_decode", 0, 8'h00, 1, 0, 8'h00, 8'h47);
        for (int i = 0; i < 3; i++) begin
            step("add_rdop_wait", 0, 8'h00, 0, 0, RD | AS, 8'h47);
        end
        step("add_rdop_done", 0, 8'h33, 1, 0, RD | AS | LA, 8'h47);
        // SKZ with zero = 1, then zero = 0
        step("skz1_fetch", 0, 8'h20, 1, 0, RD | IP, 8'h47);
        step("skz1_decode", 0, 8'h00, 1, 1, IP, 8'h20);
        step("skz0_fetch", 0, 8'h20, 1, 0, RD | IP, 8'h20);
        step("skz0_decode", 0, 8'h00, 1, 0, 8'h00, 8'h20);
        // STO 31 then HLT
        step("sto_fetch", 0, 8'hDF, 1, 0, RD | IP, 8'h20);
        step("sto_decode", 0, 8'h00, 1, 0, 8'h00, 8'hDF);
        step("sto_wrop", 0, 8'h00, 1, 0, WR | AS, 8'hDF);
        step("hlt_fetch", 0, 8'h00, 1, 0, RD | IP, 8'hDF);
        step("hlt_decode", 0, 8'hEA, 1, 1, 8'h00, 8'h00);
        for (int i = 0; i < 22; i++) begin
            step("halted", 0, 8'(i * 37), 1, 1, HT, 8'h00);
        end
        // Fetch timeout
        step("reset_from_halt", 1, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 15; i++) begin
            step("fetch_wait", 0, 8'h00, 0, 0, RD, 8'h00);
        end
        step("err_entry", 0, 8'h00, 0, 0, HT | ER, 8'h00);
        step("err_ready_ignored", 0, 8'hEA, 1, 0, HT | ER, 8'h00);
        step("err_hold", 0, 8'h00, 0, 0, HT | ER, 8'h00);
        step("reset_from_err", 1, 8'h00, 0, 0, 8'h00, 8'h00);
        // Ready on the last allowed wait cycle still completes the fetch
        for (int i = 0; i < 14; i++) begin
            step("fetch_wait_edge", 0, 8'h00, 0, 0, RD, 8'h00);
        end
        step("fetch_edge_ready", 0, 8'h41, 1, 0, RD | IP, 8'h00);
        step("add1_decode", 0, 8'h00, 1, 0, 8'h00, 8'h41);
        step("add1_rdop_wait", 0, 8'h00, 0, 0, RD | AS, 8'h41);
        // Reset during the operand wait
        step("reset_mid_rdop", 1, 8'h00, 1, 0, 8'h00, 8'h00);
        step("post_reset_fetch", 0, 8'h00, 0, 0, RD, 8'h00);
        step("post_reset_jmp", 0, 8'hEA, 1, 0, RD | IP, 8'h00);
        step("post_reset_decode", 0, 8'h00, 1, 0, LP, 8'hEA);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
